// File: rtl/pc_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
package pc_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential step or PC-relative branch target (mod 2^64).
module pc_next_calc
    import pc_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ext_imm,
    input  logic              uncond_branch,
    input  logic              cond_branch,
    input  logic              zero,
    output logic [ADDR_W-1:0] pc_next,
    output logic              taken
);

    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_tgt_pc;

    // Unconditional term dominates when both branch flags are high.
    assign taken    = uncond_branch | (cond_branch & zero);
    assign w_seq_pc = pc + PC_STEP;
    assign w_tgt_pc = pc + ext_imm;
    assign pc_next  = taken ? w_tgt_pc : w_seq_pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and IDLE/FETCH/EXEC fetch sequencer with req/ack instruction port.
// Optional taken-branch counter enabled by defining PC_BRANCH_CNT_EN.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  ext_imm,
    input  logic               uncond_branch,
    input  logic               cond_branch,
    input  logic               zero,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [31:0]        branch_cnt
);

    pc_state_e          r_state;
    pc_state_e          w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  w_pc_next;
    logic               w_taken;
    logic               w_advance;

    pc_next_calc u_pc_next_calc (
        .pc            (r_pc),
        .ext_imm       (ext_imm),
        .uncond_branch (uncond_branch),
        .cond_branch   (cond_branch),
        .zero          (zero),
        .pc_next       (w_pc_next),
        .taken         (w_taken)
    );

    assign w_advance = (r_state == EXEC) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            if ((r_state == FETCH) && imem_ack) begin
                r_instr <= imem_rdata;
            end
            if (w_advance) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign pc        = r_pc;
    assign instr     = r_instr;
    assign imem_addr = r_pc;

`ifdef PC_BRANCH_CNT_EN
    logic [31:0] r_branch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt <= '0;
        end else if (w_advance && w_taken) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
        end
    end

    assign branch_cnt = r_branch_cnt;
`else
    logic w_unused_taken;

    assign w_unused_taken = w_taken;
    assign branch_cnt     = '0;
`endif

endmodule
